// File: rtl/gci_device_endpoint_if.sv
// Node-side bus of the GCI device endpoint: request/response path plus IRQ path.
// The node drives through the master modport; the endpoint uses the slave modport.
interface gci_device_endpoint_if;
    logic        iNODE_REQ;
    logic        oNODE_BUSY;
    logic        iNODE_RW;
    logic [31:0] iNODE_ADDR;
    logic [31:0] iNODE_DATA;
    logic        oNODE_REQ;
    logic        iNODE_BUSY;
    logic [31:0] oNODE_DATA;
    logic        oNODE_IRQ_REQ;
    logic        iNODE_IRQ_BUSY;
    logic [23:0] oNODE_IRQ_DATA;
    logic        iNODE_IRQ_ACK;

    modport slave (
        input  iNODE_REQ, iNODE_RW, iNODE_ADDR, iNODE_DATA, iNODE_BUSY,
               iNODE_IRQ_BUSY, iNODE_IRQ_ACK,
        output oNODE_BUSY, oNODE_REQ, oNODE_DATA, oNODE_IRQ_REQ, oNODE_IRQ_DATA
    );

    modport master (
        output iNODE_REQ, iNODE_RW, iNODE_ADDR, iNODE_DATA, iNODE_BUSY,
               iNODE_IRQ_BUSY, iNODE_IRQ_ACK,
        input  oNODE_BUSY, oNODE_REQ, oNODE_DATA, oNODE_IRQ_REQ, oNODE_IRQ_DATA
    );
endinterface

// File: rtl/gci_device_endpoint.sv
// GCI device endpoint: internal regs at 0x00-0x0F, local user port above, read-to-clear IRQ flags.
// Define GCI_DEVICE_ENDPOINT_INTMASK_EN to implement the writable INTMASK register.
module gci_device_endpoint #(
    parameter logic [31:0] MEMSIZE     = 32'h0000_1000,
    parameter logic [7:0]  PRIORITY    = 8'h00,
    parameter logic [7:0]  USR_TIMEOUT = 8'hFF
) (
    input  logic                  iCLOCK,
    input  logic                  iRESET,
    output logic                  oDEV_VALID,
    gci_device_endpoint_if.slave  node,
    input  logic [23:0]           iEVENT,
    output logic                  oUSR_REQ,
    output logic                  oUSR_RW,
    output logic [31:0]           oUSR_ADDR,
    output logic [31:0]           oUSR_DATA,
    input  logic                  iUSR_ACK,
    input  logic [31:0]           iUSR_DATA
);

    typedef enum logic [1:0] {IDLE, LOCAL, RESP} dState_t;
    typedef enum logic [1:0] {I_IDLE, I_REQ, I_CLR} iState_t;

    dState_t     dState, dNext;
    iState_t     iState, iNext;
    logic [31:0] respData;
    logic [31:0] regRdata;
    logic [23:0] irqData;
    logic [23:0] pending;
    logic [23:0] mask;
    logic [23:0] clr;
    logic [7:0]  tmoCnt;
    logic        accept;
    logic        isInternal;
    logic        intflagRead;
    logic        tmoHit;
    logic        irqCond;

    assign accept      = (dState == IDLE) && node.iNODE_REQ;
    assign isInternal  = (node.iNODE_ADDR[31:4] == '0);
    assign intflagRead = accept && !node.iNODE_RW && isInternal && (node.iNODE_ADDR[3:2] == 2'd2);
    assign tmoHit      = (tmoCnt == USR_TIMEOUT);
    assign clr         = intflagRead ? pending : '0;
    assign irqCond     = |(pending & mask);

    always_comb begin
        regRdata = '0;
        case (node.iNODE_ADDR[3:2])
            2'd0:    regRdata = MEMSIZE;
            2'd1:    regRdata = {24'h0, PRIORITY};
            2'd2:    regRdata = {8'h0, pending};
            default: regRdata = {8'h0, mask};
        endcase
    end

`ifdef GCI_DEVICE_ENDPOINT_INTMASK_EN
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET)
            mask <= '1;
        else if (accept && node.iNODE_RW && isInternal && (node.iNODE_ADDR[3:2] == 2'd3))
            mask <= node.iNODE_DATA[23:0];
    end
`else
    assign mask = '1;
`endif

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            dState <= IDLE;
            iState <= I_IDLE;
        end else begin
            dState <= dNext;
            iState <= iNext;
        end
    end

    always_comb begin
        dNext = dState;
        case (dState)
            IDLE:    if (accept) dNext = isInternal ? RESP : LOCAL;
            LOCAL:   if (iUSR_ACK || tmoHit) dNext = RESP;
            RESP:    if (!node.iNODE_BUSY) dNext = IDLE;
            default: dNext = IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            respData  <= '0;
            oUSR_REQ  <= 1'b0;
            oUSR_RW   <= 1'b0;
            oUSR_ADDR <= '0;
            oUSR_DATA <= '0;
            tmoCnt    <= '0;
            oDEV_VALID <= 1'b0;
        end else begin
            oDEV_VALID <= 1'b1;
            oUSR_REQ   <= 1'b0;
            if (accept) begin
                if (isInternal) begin
                    respData <= node.iNODE_RW ? '0 : regRdata;
                end else begin
                    oUSR_REQ  <= 1'b1;
                    oUSR_RW   <= node.iNODE_RW;
                    oUSR_ADDR <= node.iNODE_ADDR - 32'h10;
                    oUSR_DATA <= node.iNODE_DATA;
                    tmoCnt    <= '0;
                end
            end else if (dState == LOCAL) begin
                // An ack in the timeout cycle still wins over the error response.
                if (iUSR_ACK)
                    respData <= oUSR_RW ? '0 : iUSR_DATA;
                else if (tmoHit)
                    respData <= '1;
                tmoCnt <= tmoCnt + 8'd1;
            end
        end
    end

    assign node.oNODE_REQ  = (dState == RESP);
    assign node.oNODE_BUSY = (dState != IDLE);
    assign node.oNODE_DATA = respData;

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET)
            pending <= '0;
        else
            pending <= (pending & ~clr) | iEVENT;
    end

    always_comb begin
        iNext = iState;
        if (!node.iNODE_IRQ_BUSY) begin
            case (iState)
                I_IDLE:  if (irqCond) iNext = I_REQ;
                I_REQ:   if (node.iNODE_IRQ_ACK) iNext = I_CLR;
                I_CLR:   if (intflagRead) iNext = I_IDLE;
                default: iNext = I_IDLE;
            endcase
        end
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET)
            irqData <= '0;
        else if ((iState == I_IDLE) && !node.iNODE_IRQ_BUSY && irqCond)
            irqData <= pending & mask;
    end

    assign node.oNODE_IRQ_REQ  = (iState == I_REQ);
    assign node.oNODE_IRQ_DATA = irqData;

endmodule
